// File: rtl/mogu_pkg.sv
// rtl/mogu_pkg.sv - shared constants, action codes and helpers for the mushroom spawner
package mogu_pkg;

    // Playfield geometry (11-bit unsigned pixel coordinates)
    localparam logic [10:0] BW         = 11'd240;
    localparam logic [10:0] MGMW       = 11'd16;
    localparam logic [10:0] GROUND_R   = 11'd144;
    localparam logic [10:0] SPAWN_C0   = 11'd120;
    localparam logic [10:0] SPAWN_STEP = 11'd28;
    localparam logic [10:0] LEFT_B     = 11'd5;
    localparam logic [10:0] BASE_STEP  = 11'd1;

    // Frame counter value that advances the sprites
    localparam logic [21:0] TICK_AT    = 22'd1000000;

    // Key states decoded by the spawner
    localparam logic [3:0]  PAUSE_ST   = 4'b1010;
    localparam logic [3:0]  IDLE_ST    = 4'b0000;

    // LFSR: reset value and Fibonacci taps 8,6,5,4 (bit positions 7,5,4,3)
    localparam logic [7:0]  SEED       = 8'hA5;
    localparam logic [7:0]  LFSR_TAPS  = 8'b1011_1000;

    // Mask offered after reset
    localparam logic [3:0]  RESET_MASK = 4'b0101;

    // What the current edge does to the slots, already priority-resolved
    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_HOLD  = 3'd1,
        ACT_IDLE  = 3'd2,
        ACT_SPAWN = 3'd3,
        ACT_MOVE  = 3'd4
    } act_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    // The game core must never be offered an empty wave
    function automatic logic [3:0] mask_of(input logic [3:0] n);
        return (n == 4'd0) ? 4'b1000 : n;
    endfunction

    // Speed grows by one pixel every four waves, capped at +3
    function automatic logic [10:0] step_of(input logic [5:0] wave_div4);
        return BASE_STEP + ((wave_div4 > 6'd3) ? 11'd3 : {5'd0, wave_div4});
    endfunction

    function automatic logic [10:0] spawn_col(input logic [1:0] idx);
        return SPAWN_C0 + SPAWN_STEP * {9'd0, idx};
    endfunction

endpackage

// File: rtl/mogu_slot.sv
// rtl/mogu_slot.sv - one mushroom slot: column and direction with spawn/move/edge-clamp rules
//
// Ports:
//   clk        in  1   system clock
//   i_rst_n    in  1   synchronous reset, active-low
//   i_action   in  act_t  priority-resolved action for this edge
//   i_offered  in  1   slot is in the offered mask (reloads on spawn)
//   i_live     in  1   slot is live (moves on a tick)
//   i_step     in  11  pixels per tick for the current wave
//   i_cmarry   in  11  Mario column, used only when MOGU_CHASE_EN is defined
//   o_col      out 11  current column
//
// MOGU_CHASE_EN: when defined, the slot heads toward Mario on every move tick
// before the step and edge clamp are applied.
import mogu_pkg::*;

module mogu_slot #(
    parameter logic [1:0] SLOT_IDX = 2'd0
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  act_t        i_action,
    input  logic        i_offered,
    input  logic        i_live,
    input  logic [10:0] i_step,
    input  logic [10:0] i_cmarry,
    output logic [10:0] o_col
);

    localparam logic [10:0] HOME_COL  = spawn_col(SLOT_IDX);
    localparam logic [10:0] RIGHT_LIM = BW - MGMW - 11'd1;

    logic [10:0] r_col;
    logic        r_dir;      // 0 = moving left, 1 = moving right

    logic        w_dir_eff;
    logic [10:0] w_col_nxt;
    logic        w_dir_nxt;

`ifdef MOGU_CHASE_EN
    assign w_dir_eff = (i_cmarry > r_col);
`else
    logic w_unused_cmarry;
    assign w_unused_cmarry = ^i_cmarry;
    assign w_dir_eff       = r_dir;
`endif

    // Bound checks come before the subtraction so the column never wraps
    always_comb begin
        w_col_nxt = r_col;
        w_dir_nxt = w_dir_eff;
        if (!w_dir_eff) begin
            if (r_col <= LEFT_B + i_step) begin
                w_col_nxt = LEFT_B;
                w_dir_nxt = 1'b1;
            end else begin
                w_col_nxt = r_col - i_step;
            end
        end else begin
            if (r_col + MGMW + i_step >= BW) begin
                w_col_nxt = RIGHT_LIM;
                w_dir_nxt = 1'b0;
            end else begin
                w_col_nxt = r_col + i_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_col <= HOME_COL;
            r_dir <= 1'b0;
        end else begin
            case (i_action)
                ACT_IDLE: begin
                    r_col <= HOME_COL;
                    r_dir <= 1'b0;
                end
                ACT_SPAWN: begin
                    if (i_offered) begin
                        r_col <= HOME_COL;
                        r_dir <= 1'b0;
                    end
                end
                ACT_MOVE: begin
                    if (i_live) begin
                        r_col <= w_col_nxt;
                        r_dir <= w_dir_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_col = r_col;

endmodule

// File: rtl/mogu_spawner.sv
// rtl/mogu_spawner.sv - mushroom side of the wave handshake: offers masks, spawns and moves four slots
//
// Ports:
//   clk      in  1   system clock
//   rst_n    in  1   synchronous reset, active-low
//   counter  in  22  free-running frame counter; TICK_AT moves the sprites
//   state    in  4   key state; 4'b1010 pause, 4'b0000 idle/restart
//   inspire  in  1   wave request level from the game core (rising edge = request)
//   MM       in  4   live-slot mask owned by the game core
//   Cmarry   in  11  Mario column (only used with MOGU_CHASE_EN)
//   MOGU     out 4   offered mask for the next wave, never zero
//   C1..C4   out 11  slot columns
//   R1..R4   out 11  slot rows (always the ground row)
//   wave     out 8   waves spawned since restart, saturating at 255
//
// MOGU_CHASE_EN: when defined, slots steer toward Cmarry on each move tick.
import mogu_pkg::*;

module mogu_spawner (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] counter,
    input  logic [3:0]  state,
    input  logic        inspire,
    input  logic [3:0]  MM,
    input  logic [10:0] Cmarry,
    output logic [3:0]  MOGU,
    output logic [10:0] C1,
    output logic [10:0] C2,
    output logic [10:0] C3,
    output logic [10:0] C4,
    output logic [10:0] R1,
    output logic [10:0] R2,
    output logic [10:0] R3,
    output logic [10:0] R4,
    output logic [7:0]  wave
);

    logic [7:0]  r_lfsr;
    logic        r_inspire_d;
    logic [3:0]  r_mogu;
    logic [7:0]  r_wave;

    logic        w_pause;
    logic        w_idle;
    logic        w_spawn;
    logic        w_tick;
    act_t        w_action;
    logic [10:0] w_step;
    logic [10:0] w_col [4];

    assign w_pause = (state == PAUSE_ST);
    assign w_idle  = (state == IDLE_ST);
    assign w_spawn = inspire & ~r_inspire_d;
    assign w_tick  = (counter == TICK_AT);
    assign w_step  = step_of(r_wave[7:2]);

    // Pause beats idle beats spawn beats move; a spawn swallows a coincident tick
    always_comb begin
        w_action = ACT_NONE;
        if (w_pause) begin
            w_action = ACT_HOLD;
        end else if (w_idle) begin
            w_action = ACT_IDLE;
        end else if (w_spawn) begin
            w_action = ACT_SPAWN;
        end else if (w_tick) begin
            w_action = ACT_MOVE;
        end
    end

    // MOGU only changes on the spawn edge, so the core always sees it settled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr      <= SEED;
            r_inspire_d <= 1'b0;
            r_mogu      <= RESET_MASK;
            r_wave      <= 8'd0;
        end else if (!w_pause) begin
            r_lfsr      <= lfsr_next(r_lfsr);
            r_inspire_d <= inspire;
            if (w_idle) begin
                r_mogu <= mask_of(r_lfsr[3:0]);
                r_wave <= 8'd0;
            end else if (w_spawn) begin
                r_mogu <= mask_of(r_lfsr[3:0]);
                if (r_wave != 8'd255) begin
                    r_wave <= r_wave + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_slot
        mogu_slot #(
            .SLOT_IDX (2'(g))
        ) u_slot (
            .clk       (clk),
            .i_rst_n   (rst_n),
            .i_action  (w_action),
            .i_offered (r_mogu[g]),
            .i_live    (MM[g]),
            .i_step    (w_step),
            .i_cmarry  (Cmarry),
            .o_col     (w_col[g])
        );
    end

    assign MOGU = r_mogu;
    assign wave = r_wave;
    assign C1   = w_col[0];
    assign C2   = w_col[1];
    assign C3   = w_col[2];
    assign C4   = w_col[3];
    assign R1   = GROUND_R;
    assign R2   = GROUND_R;
    assign R3   = GROUND_R;
    assign R4   = GROUND_R;

endmodule

// File: tb/tb_mogu_spawner.sv
// tb/tb_mogu_spawner.sv - directed self-checking bench for mogu_spawner
module tb_mogu_spawner;

    localparam logic [21:0] TICK = 22'd1000000;
    localparam logic [3:0]  RUN  = 4'b0001;
    localparam logic [3:0]  PAUS = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [21:0] counter;
    logic [3:0]  state;
    logic        inspire;
    logic [3:0]  MM;
    logic [10:0] Cmarry;
    logic [3:0]  MOGU;
    logic [10:0] C1, C2, C3, C4, R1, R2, R3, R4;
    logic [7:0]  wave;

    int n_vec = 0;
    int n_err = 0;

    // Independent LFSR reference: taps 8,6,5,4, seed A5, frozen in pause
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else if (state != PAUS) m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] exp_mask(input logic [7:0] l);
        return (l[3:0] == 4'd0) ? 4'b1000 : l[3:0];
    endfunction

    always #5 clk = ~clk;

    mogu_spawner dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .counter (counter),
        .state   (state),
        .inspire (inspire),
        .MM      (MM),
        .Cmarry  (Cmarry),
        .MOGU    (MOGU),
        .C1      (C1),
        .C2      (C2),
        .C3      (C3),
        .C4      (C4),
        .R1      (R1),
        .R2      (R2),
        .R3      (R3),
        .R4      (R4),
        .wave    (wave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        inspire = 1'b0;
        counter = 22'd0;
        MM      = 4'd0;
        Cmarry  = 11'd0;
        state   = RUN;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic ticks(input int n);
        counter = TICK;
        repeat (n) step();
        counter = 22'd0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (MOGU !== 4'b0101) begin n_err++; $display("FAIL reset_mogu got %b want 0101", MOGU); end
        n_vec++; if (C1 !== 11'd120) begin n_err++; $display("FAIL reset_c1 got %0d want 120", C1); end
        n_vec++; if (C2 !== 11'd148) begin n_err++; $display("FAIL reset_c2 got %0d want 148", C2); end
        n_vec++; if (C3 !== 11'd176) begin n_err++; $display("FAIL reset_c3 got %0d want 176", C3); end
        n_vec++; if (C4 !== 11'd204) begin n_err++; $display("FAIL reset_c4 got %0d want 204", C4); end
        n_vec++; if ({R1, R2, R3, R4} !== {4{11'd144}}) begin n_err++; $display("FAIL reset_rows got %0d %0d %0d %0d want 144", R1, R2, R3, R4); end
        n_vec++; if (wave !== 8'd0) begin n_err++; $display("FAIL reset_wave got %0d want 0", wave); end
    endtask

    task automatic test_spawn();
        logic [3:0] exp;
        do_reset();
        inspire = 1'b1;
        exp = exp_mask(m_lfsr);
        step();
        n_vec++; if (C1 !== 11'd120 || C3 !== 11'd176) begin n_err++; $display("FAIL spawn_cols got %0d %0d want 120 176", C1, C3); end
        n_vec++; if (wave !== 8'd1) begin n_err++; $display("FAIL spawn_wave got %0d want 1", wave); end
        n_vec++; if (MOGU !== exp || MOGU === 4'd0) begin n_err++; $display("FAIL spawn_mask got %b want %b", MOGU, exp); end
        repeat (10) step();
        n_vec++; if (wave !== 8'd1 || MOGU !== exp) begin n_err++; $display("FAIL level_no_respawn got wave %0d mask %b want 1 %b", wave, MOGU, exp); end
        inspire = 1'b0;
        step();
    endtask

    task automatic test_bounce_left();
        do_reset();
        MM = 4'b0001;
        ticks(113);
        n_vec++; if (C1 !== 11'd7) begin n_err++; $display("FAIL left_approach got %0d want 7", C1); end
        ticks(1);
        n_vec++; if (C1 !== 11'd6) begin n_err++; $display("FAIL left_t1 got %0d want 6", C1); end
        ticks(1);
        n_vec++; if (C1 !== 11'd5) begin n_err++; $display("FAIL left_clamp got %0d want 5", C1); end
        ticks(1);
        n_vec++; if (C1 !== 11'd6) begin n_err++; $display("FAIL left_rebound got %0d want 6", C1); end
        n_vec++; if (C2 !== 11'd148) begin n_err++; $display("FAIL dead_slot_hold got %0d want 148", C2); end
    endtask

    task automatic test_bounce_right();
        do_reset();
        repeat (12) begin
            inspire = 1'b1; step();
            inspire = 1'b0; step();
        end
        n_vec++; if (wave !== 8'd12) begin n_err++; $display("FAIL wave12 got %0d want 12", wave); end
        MM = 4'b0010;
        ticks(36);
        n_vec++; if (C2 !== 11'd5) begin n_err++; $display("FAIL step4_left_clamp got %0d want 5", C2); end
        ticks(54);
        n_vec++; if (C2 !== 11'd221) begin n_err++; $display("FAIL step4_approach got %0d want 221", C2); end
        ticks(1);
        n_vec++; if (C2 !== 11'd223) begin n_err++; $display("FAIL right_clamp got %0d want 223", C2); end
        ticks(1);
        n_vec++; if (C2 !== 11'd219) begin n_err++; $display("FAIL right_rebound got %0d want 219", C2); end
    endtask

    task automatic test_pause();
        logic [3:0] exp;
        do_reset();
        MM = 4'b1111;
        ticks(2);
        state   = PAUS;
        counter = TICK;
        step();
        inspire = 1'b1;
        step();
        step();
        n_vec++; if ({C1, C2, C3, C4} !== {11'd118, 11'd146, 11'd174, 11'd202}) begin n_err++; $display("FAIL pause_cols got %0d %0d %0d %0d want 118 146 174 202", C1, C2, C3, C4); end
        n_vec++; if (MOGU !== 4'b0101 || wave !== 8'd0) begin n_err++; $display("FAIL pause_regs got %b %0d want 0101 0", MOGU, wave); end
        state   = RUN;
        counter = 22'd0;
        exp = exp_mask(m_lfsr);
        step();
        n_vec++; if ({C1, C2, C3, C4} !== {11'd120, 11'd146, 11'd176, 11'd202}) begin n_err++; $display("FAIL unpause_spawn_cols got %0d %0d %0d %0d want 120 146 176 202", C1, C2, C3, C4); end
        n_vec++; if (MOGU !== exp || wave !== 8'd1) begin n_err++; $display("FAIL unpause_spawn got %b %0d want %b 1", MOGU, wave, exp); end
        inspire = 1'b0;
        step();
    endtask

    task automatic test_spawn_tick();
        do_reset();
        MM = 4'b1111;
        ticks(3);
        counter = TICK;
        inspire = 1'b1;
        step();
        counter = 22'd0;
        inspire = 1'b0;
        n_vec++; if ({C1, C2, C3, C4} !== {11'd120, 11'd145, 11'd176, 11'd201}) begin n_err++; $display("FAIL spawn_beats_tick got %0d %0d %0d %0d want 120 145 176 201", C1, C2, C3, C4); end
        n_vec++; if (wave !== 8'd1) begin n_err++; $display("FAIL spawn_tick_wave got %0d want 1", wave); end
        step();
    endtask

    task automatic test_chase();
        do_reset();
        MM = 4'b0001;
        ticks(70);
        n_vec++; if (C1 !== 11'd50) begin n_err++; $display("FAIL chase_setup got %0d want 50", C1); end
        Cmarry = 11'd200;
        ticks(1);
`ifdef MOGU_CHASE_EN
        n_vec++; if (C1 !== 11'd51) begin n_err++; $display("FAIL chase_turn got %0d want 51", C1); end
`else
        n_vec++; if (C1 !== 11'd49) begin n_err++; $display("FAIL no_chase got %0d want 49", C1); end
`endif
        Cmarry = 11'd0;
    endtask

    task automatic test_idle();
        logic [3:0] exp;
        do_reset();
        inspire = 1'b1; step();
        inspire = 1'b0; step();
        MM = 4'b1111;
        ticks(5);
        state = 4'b0000;
        exp = exp_mask(m_lfsr);
        step();
        state = RUN;
        n_vec++; if ({C1, C2, C3, C4} !== {11'd120, 11'd148, 11'd176, 11'd204}) begin n_err++; $display("FAIL idle_cols got %0d %0d %0d %0d want 120 148 176 204", C1, C2, C3, C4); end
        n_vec++; if (wave !== 8'd0 || MOGU !== exp) begin n_err++; $display("FAIL idle_regs got %0d %b want 0 %b", wave, MOGU, exp); end
    endtask

    task automatic test_wave_saturate();
        logic [3:0] exp;
        int bad = 0;
        do_reset();
        repeat (260) begin
            inspire = 1'b1;
            exp = exp_mask(m_lfsr);
            step();
            if (MOGU !== exp) bad++;
            inspire = 1'b0;
            step();
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL mask_sequence got %0d wrong masks want 0", bad); end
        n_vec++; if (wave !== 8'd255) begin n_err++; $display("FAIL wave_saturate got %0d want 255", wave); end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_bounce_left();
        test_bounce_right();
        test_pause();
        test_spawn_tick();
        test_chase();
        test_idle();
        test_wave_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
